alu_op_sequencer: RTL

Multi-cycle controller that sequences one ALU operation over the single-port, 4-entry, 8-bit register file: reads operand A, reads operand B, computes, writes the result back, then signals completion. Sits between the instruction/command source and the register file; it is the only master of the register file's address, write-enable and data lines. The top level joins the split data buses (RF_Write_Data / RF_Read_Data) to the register file's bidirectional Data bus, driving it only while RF_Write_Enable is high.

---
 rtl/alu_op_sequencer_if.sv | 25 ++
 rtl/alu_op_sequencer.sv | 87 ++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command/status and register-file bus of the ALU op sequencer
interface alu_op_sequencer_if #(parameter int WIDTH = 8, parameter int ADDR_WIDTH = 2);
  logic                  Start;
  logic [2:0]            Opcode;
  logic [ADDR_WIDTH-1:0] Src_A;
  logic [ADDR_WIDTH-1:0] Src_B;
  logic [ADDR_WIDTH-1:0] Dest;
  logic                  Ready;
  logic                  Done;
  logic [WIDTH-1:0]      Result;
  logic                  Carry;
  logic                  Zero;
  logic [ADDR_WIDTH-1:0] RF_Address;
  logic                  RF_Write_Enable;
  logic [WIDTH-1:0]      RF_Write_Data;
  logic [WIDTH-1:0]      RF_Read_Data;
  modport master (
    output Start, Opcode, Src_A, Src_B, Dest, RF_Read_Data,
    input  Ready, Done, Result, Carry, Zero, RF_Address, RF_Write_Enable, RF_Write_Data
  );
  modport slave (
    input  Start, Opcode, Src_A, Src_B, Dest, RF_Read_Data,
    output Ready, Done, Result, Carry, Zero, RF_Address, RF_Write_Enable, RF_Write_Data
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences read A, read B, execute, write-back over a single-port register file
module alu_op_sequencer #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 2
) (
  input logic              Clock,
  input logic              Reset_n,
  alu_op_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ_A = 3'd1;
  localparam logic [2:0] READ_B = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] OP_CMP = 3'b111;
  logic [2:0]            state;
  logic [2:0]            opcode;
  logic [ADDR_WIDTH-1:0] src_a, src_b, dest;
  logic [WIDTH-1:0]      op_a, op_b, result;
  logic                  carry, zero;
  logic [WIDTH:0]        alu;
  // MSB of alu is the carry/borrow; logic ops zero-extend so their carry is 0
  always_comb begin
    alu = '0;
    case (opcode)
      3'b000:  alu = {1'b0, op_a} + {1'b0, op_b};
      3'b010:  alu = {1'b0, op_a & op_b};
      3'b011:  alu = {1'b0, op_a | op_b};
      3'b100:  alu = {1'b0, op_a ^ op_b};
      3'b101:  alu = {1'b0, ~op_a};
      3'b110:  alu = {op_a, 1'b0};
      default: alu = {1'b0, op_a} - {1'b0, op_b};
    endcase
  end
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      opcode <= '0;
      src_a  <= '0;
      src_b  <= '0;
      dest   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.Start) begin
          state  <= READ_A;
          opcode <= bus.Opcode;
          src_a  <= bus.Src_A;
          src_b  <= bus.Src_B;
          dest   <= bus.Dest;
        end
        READ_A: begin
          op_a  <= bus.RF_Read_Data;
          state <= READ_B;
        end
        READ_B: begin
          op_b  <= bus.RF_Read_Data;
          state <= EXEC;
        end
        EXEC: begin
          result <= alu[WIDTH-1:0];
          carry  <= alu[WIDTH];
          zero   <= alu[WIDTH-1:0] == '0;
          state  <= opcode == OP_CMP ? DONE : WRITE;
        end
        WRITE:   state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
  // All outputs decode registered state, so reset removes the write strobe without a clock
  assign bus.Ready           = state == IDLE;
  assign bus.Done            = state == DONE;
  assign bus.Result          = result;
  assign bus.Carry           = carry;
  assign bus.Zero            = zero;
  assign bus.RF_Write_Enable = state == WRITE;
  assign bus.RF_Write_Data   = state == WRITE ? result : '0;
  assign bus.RF_Address      = state == READ_A ? src_a :
                               state == READ_B ? src_b :
                               state == WRITE  ? dest  : '0;
endmodule
